// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, and helpers for constant sizing,
// baud divisor calculation and majority voting.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 32'sd0;
    v = value - 32'sd1;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    return r;
  endfunction

  // Rounded clock cycles per oversampling tick.
  function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
    longint den;
    den = longint'(baud) * longint'(oversample);
    return int'((longint'(clk_freq) + den / 64'sd2) / den);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with wrap-bit pointers; the read port keeps showing
// the last popped word while the FIFO is empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [DATA_W-1:0]      wdata_i,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [clog2(DEPTH):0]  level_o
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_ok_s;
  logic              pop_ok_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign pop_ok_s  = pop_i & ~empty_o;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign push_ok_s = push_i & (~full_o | pop_ok_s);
  assign rdata_o   = empty_o ? last_q : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      last_d   = mem_q[rd_ptr_q[AW-1:0]];
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// UART receiver: 2-flop synchroniser, oversampling tick, 3-sample mid-bit vote,
// frame FSM and output FIFO. Define UART_RX_PARITY_EN to receive a parity bit.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun,
  output logic [clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int DIV   = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int CNT_W = (DIV > 1) ? clog2(DIV) : 1;
  localparam int IDX_W = clog2(OVERSAMPLE);
  localparam int BIT_W = clog2(DATA_W);
  localparam int HALF  = OVERSAMPLE / 2;

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_S0  = IDX_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_S1  = IDX_W'(HALF);
  localparam logic [IDX_W-1:0] IDX_DEC = IDX_W'(HALF + 1);
  localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(DATA_W - 1);
  localparam logic             ODD_BIT = (PARITY_ODD != 0);

  uart_state_e       state_q, state_d;
  logic              rx_meta_q, rx_sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt_s;
  logic [1:0]        smp_q, smp_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              frame_err_q, frame_err_d;
  logic              parity_err_q, parity_err_d;
  logic              overrun_q, overrun_d;
  logic              tick_s, decide_s, vote_s, start_edge_s, par_bad_s, push_s;
  logic              fifo_full_s, fifo_empty_s;

  assign tick_s       = (cnt_q == CNT_TOP);
  assign idx_nxt_s    = (idx_q == IDX_TOP) ? '0 : idx_q + IDX_W'(1);
  // Third sample arrives on the decision tick, so it is voted straight from the synchroniser.
  assign decide_s     = tick_s & (idx_nxt_s == IDX_DEC);
  assign vote_s       = maj3(smp_q[1], smp_q[0], rx_sync_q);
  assign start_edge_s = (state_q == ST_IDLE) & ~rx_sync_q;

`ifdef UART_RX_PARITY_EN
  assign par_bad_s = par_q ^ ODD_BIT;
`else
  logic unused_parity_s;
  assign unused_parity_s = par_q ^ ODD_BIT;
  assign par_bad_s       = 1'b0;
`endif

  // Two-flop synchroniser, preset to idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync_q) state_d = ST_START;
        else            state_d = ST_IDLE;
      end
      ST_START: begin
        if (decide_s) state_d = vote_s ? ST_IDLE : ST_DATA;
        else          state_d = ST_START;
      end
      ST_DATA: begin
        if (decide_s && (bit_cnt_q == BIT_TOP)) begin
`ifdef UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (decide_s) state_d = ST_STOP;
        else          state_d = ST_PARITY;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (decide_s) state_d = ST_IDLE;
        else          state_d = ST_STOP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: frame verdict at the stop-bit decision.
  always_comb begin
    push_s       = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    if ((state_q == ST_STOP) && decide_s) begin
      if (!vote_s)        frame_err_d  = 1'b1;
      else if (par_bad_s) parity_err_d = 1'b1;
      else                push_s       = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  assign overrun_d = push_s & fifo_full_s & ~rx_ready;

  // Tick timing, vote samples, shift register and running parity.
  always_comb begin
    cnt_d     = tick_s ? '0 : cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    smp_d     = smp_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    if (start_edge_s) begin
      cnt_d     = '0;
      idx_d     = '0;
      bit_cnt_d = '0;
      par_d     = 1'b0;
    end else begin
      if (tick_s) begin
        idx_d = idx_nxt_s;
        if (idx_nxt_s == IDX_S0)      smp_d[1] = rx_sync_q;
        else if (idx_nxt_s == IDX_S1) smp_d[0] = rx_sync_q;
        else                          smp_d    = smp_q;
      end else begin
        idx_d = idx_q;
      end
      if (decide_s && (state_q == ST_DATA)) begin
        shift_d   = {vote_s, shift_q[DATA_W-1:1]};
        bit_cnt_d = (bit_cnt_q == BIT_TOP) ? '0 : bit_cnt_q + BIT_W'(1);
        par_d     = par_q ^ vote_s;
      end else if (decide_s && (state_q == ST_PARITY)) begin
        par_d = par_q ^ vote_s;
      end else begin
        shift_d = shift_q;
      end
    end
  end

  // Datapath and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      smp_q        <= 2'b11;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      smp_q        <= smp_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign rx_valid   = ~fifo_empty_s;

  uart_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (rx_ready),
    .wdata_i (shift_q),
    .rdata_o (rx_data),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level)
  );

endmodule
